// File: rtl/answers_link_pkg.sv
// Shared definitions for the answer-table link: FSM encoding, character framing and checksum helper.
// Used by the frame transmitter, the answers ROM and the receiver.
package answers_link_pkg;

    localparam int WORD_W     = 8;
    localparam int CHAR_BITS  = 10;
    localparam int NWORDS_DEF = 20;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_ADDR  = 3'd1;
    localparam state_t ST_WAIT  = 3'd2;
    localparam state_t ST_LOAD  = 3'd3;
    localparam state_t ST_SHIFT = 3'd4;
    localparam state_t ST_CLOAD = 3'd5;

    // Modulo-256 running sum; the carry out is dropped on purpose.
    function automatic logic [WORD_W-1:0] csum_add(input logic [WORD_W-1:0] acc,
                                                   input logic [WORD_W-1:0] val);
        csum_add = acc + val;
    endfunction

endpackage

// File: rtl/answers_bit_serializer.sv
// UART-style character framer: start bit, 8 data bits LSB first, stop bit; CLK_DIV clocks per bit.
// char_done flags the last clock of the stop bit so the caller can react on that same edge.
module answers_bit_serializer
    import answers_link_pkg::*;
#(
    parameter int CLK_DIV = 8
) (
    input  logic              clk80MHz,
    input  logic              rst,
    input  logic              load,
    input  logic [WORD_W-1:0] char_data,
    output logic              tx,
    output logic              char_done
);

    localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [WORD_W-1:0] shreg_r;
    logic [TW-1:0]     timer_r;
    logic [3:0]        bit_r;
    logic              active_r;
    logic              tx_r;
    logic              tick_s;
    logic              next_tx_s;

    // Bit-period terminal count, end of frame and the level of the following bit.
    always_comb begin
        tick_s    = active_r && (timer_r == TW'(CLK_DIV - 1));
        char_done = tick_s && (bit_r == 4'(CHAR_BITS - 1));
        if (bit_r < 4'd8) begin
            next_tx_s = shreg_r[bit_r[2:0]];
        end else begin
            next_tx_s = 1'b1;
        end
    end

    // Shift state: a load starts the start bit immediately on the registered line.
    always_ff @(posedge clk80MHz or negedge rst) begin
        if (!rst) begin
            shreg_r  <= 8'h00;
            timer_r  <= '0;
            bit_r    <= 4'd0;
            active_r <= 1'b0;
            tx_r     <= 1'b1;
        end else if (load) begin
            shreg_r  <= char_data;
            timer_r  <= '0;
            bit_r    <= 4'd0;
            active_r <= 1'b1;
            tx_r     <= 1'b0;
        end else if (active_r) begin
            if (tick_s) begin
                timer_r <= '0;
                if (bit_r == 4'(CHAR_BITS - 1)) begin
                    bit_r    <= 4'd0;
                    active_r <= 1'b0;
                    tx_r     <= 1'b1;
                end else begin
                    bit_r <= bit_r + 4'd1;
                    tx_r  <= next_tx_s;
                end
            end else begin
                timer_r <= timer_r + TW'(1);
            end
        end else begin
            tx_r <= 1'b1;
        end
    end

    assign tx = tx_r;

endmodule

// File: rtl/answers_frame_tx.sv
// Frame sequencer: fetches NWORDS table words from the answers ROM and sends them, then an
// 8-bit modular checksum, as serial characters on tx.
module answers_frame_tx
    import answers_link_pkg::*;
#(
    parameter int NWORDS  = NWORDS_DEF,
    parameter int AW      = 5,
    parameter int CLK_DIV = 8
) (
    input  logic              clk80MHz,
    input  logic              rst,
    input  logic              req,
    output logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] data,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    state_t            state_r;
    logic [AW-1:0]     idx_r;
    logic [AW-1:0]     addr_r;
    logic [WORD_W-1:0] csum_r;
    logic              busy_r;
    logic              done_r;
    logic              csum_char_r;
    logic              load_s;
    logic [WORD_W-1:0] char_s;
    logic              char_done_s;

    // Serializer feed: the ROM word in LOAD, the accumulated checksum in CLOAD.
    always_comb begin
        load_s = 1'b0;
        char_s = data;
        if (state_r == ST_LOAD) begin
            load_s = 1'b1;
            char_s = data;
        end else if (state_r == ST_CLOAD) begin
            load_s = 1'b1;
            char_s = csum_r;
        end else begin
            load_s = 1'b0;
            char_s = data;
        end
    end

    // Frame FSM. addr is non-zero for a single cycle per fetch because the ROM frame
    // counter advances on every cycle that addr holds the last index.
    always_ff @(posedge clk80MHz or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            idx_r       <= '0;
            addr_r      <= '0;
            csum_r      <= 8'h00;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            csum_char_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req) begin
                        state_r     <= ST_ADDR;
                        idx_r       <= '0;
                        csum_r      <= 8'h00;
                        busy_r      <= 1'b1;
                        csum_char_r <= 1'b0;
                    end
                end
                ST_ADDR: begin
                    addr_r  <= idx_r;
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    addr_r  <= '0;
                    state_r <= ST_LOAD;
                end
                ST_LOAD: begin
                    csum_r  <= csum_add(csum_r, data);
                    state_r <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (char_done_s) begin
                        if (csum_char_r) begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else if (idx_r == AW'(NWORDS - 1)) begin
                            state_r <= ST_CLOAD;
                        end else begin
                            idx_r   <= idx_r + AW'(1);
                            state_r <= ST_ADDR;
                        end
                    end
                end
                ST_CLOAD: begin
                    csum_char_r <= 1'b1;
                    state_r     <= ST_SHIFT;
                end
                default: begin
                    state_r <= ST_IDLE;
                    addr_r  <= '0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    answers_bit_serializer #(.CLK_DIV(CLK_DIV)) u_ser (
        .clk80MHz  (clk80MHz),
        .rst       (rst),
        .load      (load_s),
        .char_data (char_s),
        .tx        (tx),
        .char_done (char_done_s)
    );

    assign addr = addr_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_answers_frame_tx.sv
// Directed bench: two transmitters (CLK_DIV=8 and CLK_DIV=1) with answers-ROM models and a
// UART decoder on each tx line; expected bytes, checksums and frame lengths are hand-computed.
module tb_answers_frame_tx;

    logic       clk80MHz = 1'b0;
    logic       rst      = 1'b0;
    logic       req_a    = 1'b0;
    logic       req_b    = 1'b0;
    logic [4:0] addr_a, addr_b;
    logic [7:0] data_a   = 8'h00;
    logic [7:0] data_b   = 8'h00;
    logic       tx_a, tx_b, busy_a, busy_b, done_a, done_b;

    logic [7:0] rom_cnt_a   = 8'h00;
    logic [7:0] rom_cnt_b   = 8'h00;
    logic       rom_load_a  = 1'b0;
    logic [7:0] rom_load_v  = 8'h00;

    logic [7:0] rxq_a[$];
    logic [7:0] rxq_b[$];
    logic [4:0] addrq_a[$];
    int         done_cnt_a  = 0;
    int         stop_err    = 0;
    int         n_cmp       = 0;
    int         n_bad       = 0;

    answers_frame_tx #(.NWORDS(20), .AW(5), .CLK_DIV(8)) dut_a (
        .clk80MHz(clk80MHz), .rst(rst), .req(req_a), .addr(addr_a), .data(data_a),
        .tx(tx_a), .busy(busy_a), .done(done_a));

    answers_frame_tx #(.NWORDS(20), .AW(5), .CLK_DIV(1)) dut_b (
        .clk80MHz(clk80MHz), .rst(rst), .req(req_b), .addr(addr_b), .data(data_b),
        .tx(tx_b), .busy(busy_b), .done(done_b));

    always #5 clk80MHz = ~clk80MHz;

    // Answers ROM models: word 0 is the frame counter, word k is 10*k; counter steps on addr==19.
    always @(posedge clk80MHz) begin
        data_a    <= (addr_a == 5'd0) ? rom_cnt_a : 8'(8'd10 * 8'(addr_a));
        data_b    <= (addr_b == 5'd0) ? rom_cnt_b : 8'(8'd10 * 8'(addr_b));
        rom_cnt_a <= rom_load_a ? rom_load_v : ((addr_a == 5'd19) ? rom_cnt_a + 8'd1 : rom_cnt_a);
        rom_cnt_b <= (addr_b == 5'd19) ? rom_cnt_b + 8'd1 : rom_cnt_b;
    end

    // UART decoders and activity monitors, sampled on the falling edge.
    initial begin
        bit         act[2];
        int         cnt[2];
        logic [7:0] sh[2];
        int         dv, b;
        logic       t;
        act[0] = 1'b0; act[1] = 1'b0;
        cnt[0] = 0;    cnt[1] = 0;
        forever begin
            @(negedge clk80MHz);
            for (int d = 0; d < 2; d++) begin
                t  = (d == 0) ? tx_a : tx_b;
                dv = (d == 0) ? 8 : 1;
                if (!rst) begin
                    act[d] = 1'b0;
                end else if (!act[d]) begin
                    if (!t) begin
                        act[d] = 1'b1;
                        cnt[d] = 0;
                    end
                end else begin
                    cnt[d]++;
                    if ((cnt[d] % dv) == (dv / 2)) begin
                        b = cnt[d] / dv;
                        if (b >= 1 && b <= 8) begin
                            sh[d][b-1] = t;
                        end else if (b == 9) begin
                            if (!t) stop_err++;
                            if (d == 0) rxq_a.push_back(sh[d]);
                            else        rxq_b.push_back(sh[d]);
                            act[d] = 1'b0;
                        end
                    end
                end
            end
            if (addr_a != 5'd0) addrq_a.push_back(addr_a);
            if (done_a) done_cnt_a++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Caller is at a falling edge; req is raised now, E is the next rising edge and
    // frame cycle 0 is the falling edge right after E. Returns the cycle where done is seen.
    task automatic run_frame(input bit sel, input bit extra_req, output int ncyc);
        int n;
        if (sel) req_b = 1'b1; else req_a = 1'b1;
        @(negedge clk80MHz);
        req_a = 1'b0; req_b = 1'b0;
        n = 0;
        while (n < 4000 && !(sel ? done_b : done_a)) begin
            @(negedge clk80MHz);
            n++;
            req_a = extra_req && (n == 5 || n == 900);
        end
        req_a = 1'b0;
        check_eq("frame_timeout", (n < 4000) ? 32'd1 : 32'd0, 32'd1);
        ncyc = n;
    endtask

    task automatic check_frame(input string tag, input bit sel, input int base,
                               input logic [7:0] w0, input logic [7:0] csum);
        int         sz;
        logic [7:0] exp_b, got;
        sz = sel ? rxq_b.size() : rxq_a.size();
        check_eq({tag, "_nchars"}, 32'(sz - base), 32'd21);
        if (sz - base >= 21) begin
            for (int k = 0; k < 21; k++) begin
                got   = sel ? rxq_b[base + k] : rxq_a[base + k];
                exp_b = (k == 0) ? w0 : ((k == 20) ? csum : 8'(10 * k));
                check_eq($sformatf("%s_char%0d", tag, k), 32'(got), 32'(exp_b));
            end
        end
    endtask

    initial begin
        int n, base, abase, dbase;

        // Reset state
        repeat (3) @(negedge clk80MHz);
        check_eq("rst_tx", 32'(tx_a), 32'd1);
        check_eq("rst_busy", 32'(busy_a), 32'd0);
        check_eq("rst_done", 32'(done_a), 32'd0);
        check_eq("rst_addr", 32'(addr_a), 32'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk80MHz);

        // Test 1: reset at cycle 500 of a frame aborts at once, no done pulse
        dbase = done_cnt_a;
        req_a = 1'b1;
        @(negedge clk80MHz);
        req_a = 1'b0;
        repeat (500) @(negedge clk80MHz);
        check_eq("abort_busy_before", 32'(busy_a), 32'd1);
        rst = 1'b0;
        #1;
        check_eq("abort_tx", 32'(tx_a), 32'd1);
        check_eq("abort_busy", 32'(busy_a), 32'd0);
        check_eq("abort_addr", 32'(addr_a), 32'd0);
        repeat (4) @(negedge clk80MHz);
        rst = 1'b1;
        repeat (20) @(negedge clk80MHz);
        check_eq("abort_no_done", 32'(done_cnt_a - dbase), 32'd0);
        check_eq("abort_idle", 32'(busy_a), 32'd0);

        // Test 2: first frame, bytes 0,10..190 and checksum 0x6C, done at cycle 1741
        base  = rxq_a.size();
        abase = addrq_a.size();
        run_frame(1'b0, 1'b0, n);
        check_eq("f1_len", 32'(n), 32'd1741);
        check_eq("f1_busy_in_done", 32'(busy_a), 32'd0);
        check_frame("f1", 1'b0, base, 8'd0, 8'h6C);
        check_eq("f1_addr_count", 32'(addrq_a.size() - abase), 32'd19);
        if (addrq_a.size() - abase >= 19)
            for (int k = 0; k < 19; k++)
                check_eq($sformatf("f1_addr%0d", k + 1), 32'(addrq_a[abase + k]), 32'(k + 1));

        // Test 3: back-to-back request in the done cycle
        base = rxq_a.size();
        run_frame(1'b0, 1'b0, n);
        check_eq("f2_len", 32'(n), 32'd1741);
        check_frame("f2", 1'b0, base, 8'd1, 8'h6D);
        check_eq("f2_romcnt", 32'(rom_cnt_a), 32'd2);

        // Test 4: requests while busy are ignored and not queued
        repeat (10) @(negedge clk80MHz);
        base  = rxq_a.size();
        dbase = done_cnt_a;
        run_frame(1'b0, 1'b1, n);
        check_eq("f3_len", 32'(n), 32'd1741);
        repeat (60) @(negedge clk80MHz);
        check_eq("f3_one_done", 32'(done_cnt_a - dbase), 32'd1);
        check_eq("f3_not_queued", 32'(busy_a), 32'd0);
        check_frame("f3", 1'b0, base, 8'd2, 8'h6E);

        // Test 5: ROM counter wrap 255 -> 0
        rom_load_v = 8'd255;
        rom_load_a = 1'b1;
        @(negedge clk80MHz);
        rom_load_a = 1'b0;
        repeat (5) @(negedge clk80MHz);
        base = rxq_a.size();
        run_frame(1'b0, 1'b0, n);
        check_frame("wrap", 1'b0, base, 8'd255, 8'h6B);
        repeat (5) @(negedge clk80MHz);
        base = rxq_a.size();
        run_frame(1'b0, 1'b0, n);
        check_frame("postwrap", 1'b0, base, 8'd0, 8'h6C);

        // Test 6: CLK_DIV=1 instance, 271-cycle frame, same bytes as the first frame
        repeat (5) @(negedge clk80MHz);
        base = rxq_b.size();
        run_frame(1'b1, 1'b0, n);
        check_eq("div1_len", 32'(n), 32'd271);
        check_frame("div1", 1'b1, base, 8'd0, 8'h6C);

        check_eq("stop_bits", 32'(stop_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
